// File: rtl/fft4_input_buffer.sv
// fft4_input_buffer: collects four complex samples x0..x3 arriving in natural order
// and presents them as the two stage-1 butterfly operand pairs (x0,x2) and (x1,x3).
// Optional build macro FFT4_BUF_PINGPONG_EN selects two banks (write one frame while
// the other is being presented); undefined gives a single bank.
module fft4_input_buffer #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] pair0_1,
  output logic [DATAWIDTH-1:0] pair0_2,
  output logic [DATAWIDTH-1:0] pair1_1,
  output logic [DATAWIDTH-1:0] pair1_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sop_err
);

`ifdef FFT4_BUF_PINGPONG_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_state_e;
  typedef logic [DATAWIDTH-1:0] sample_t;

  // Slot order inside a bank: 0 = pair0_1, 1 = pair0_2, 2 = pair1_1, 3 = pair1_2,
  // i.e. sample k lands in slot bitrev(k).
  bank_state_e state_q [NumBanks];
  bank_state_e state_d [NumBanks];
  sample_t     slot_q  [NumBanks][4];
  sample_t     slot_d  [NumBanks][4];
  sample_t     pair_q  [4];
  sample_t     pair_d  [4];
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        sop_err_q, sop_err_d;
  logic        in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // State register: banks, pointers, write index and presented pair registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '{default: StEmpty};
      slot_q    <= '{default: '0};
      pair_q    <= '{default: '0};
      wr_idx_q  <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      sop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      pair_q    <= pair_d;
      wr_idx_q  <= wr_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sop_err_q <= sop_err_d;
    end
  end

  // Next-state: retire the read bank on output transfer, store accepted samples
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    wr_idx_d  = wr_idx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sop_err_d = 1'b0;
    pair_d    = pair_q;

    // A FULL read bank is never the write bank in the same cycle, so the two
    // updates below never touch the same bank.
    if (out_xfer) begin
      state_d[rd_ptr_q] = StEmpty;
`ifdef FFT4_BUF_PINGPONG_EN
      rd_ptr_d = ~rd_ptr_q;
`endif
    end

    if (in_xfer) begin
      if (in_sop && (wr_idx_q != 2'd0)) begin
        // Restart: drop the partial frame, this sample becomes x0
        slot_d[wr_ptr_q][0] = in_data;
        wr_idx_d            = 2'd1;
        state_d[wr_ptr_q]   = StFilling;
        sop_err_d           = 1'b1;
      end else begin
        slot_d[wr_ptr_q][{wr_idx_q[0], wr_idx_q[1]}] = in_data;
        wr_idx_d = wr_idx_q + 2'd1;
        if (wr_idx_q == 2'd3) begin
          state_d[wr_ptr_q] = StFull;
`ifdef FFT4_BUF_PINGPONG_EN
          wr_ptr_d = ~wr_ptr_q;
`endif
        end else begin
          state_d[wr_ptr_q] = StFilling;
        end
      end
    end

    // Present whichever bank will be FULL on the read side; otherwise hold
    if (state_d[rd_ptr_d] == StFull) begin
      pair_d = slot_d[rd_ptr_d];
    end
  end

  // Outputs: handshakes derived purely from registered state
  always_comb begin
    in_ready  = (state_q[wr_ptr_q] != StFull);
    out_valid = (state_q[rd_ptr_q] == StFull);
    sop_err   = sop_err_q;
    pair0_1   = pair_q[0];
    pair0_2   = pair_q[1];
    pair1_1   = pair_q[2];
    pair1_2   = pair_q[3];
  end

endmodule

// File: tb/tb_fft4_input_buffer.sv
// Bench for fft4_input_buffer: directed scenarios plus random traffic, checked
// against a frame-level reference model (queues of samples and whole frames).
module tb_fft4_input_buffer;
  localparam int DW = 32;
`ifdef FFT4_BUF_PINGPONG_EN
  localparam int StreamCycles = 32;
`else
  localparam int StreamCycles = 40;
`endif

  typedef logic [DW-1:0]   sample_t;
  typedef logic [4*DW-1:0] frame_t;
  typedef struct packed {logic sop; sample_t data;} item_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b1;
  sample_t in_data = '0;
  logic    in_valid = 1'b0;
  logic    in_sop = 1'b0;
  logic    in_ready;
  sample_t pair0_1, pair0_2, pair1_1, pair1_2;
  logic    out_valid;
  logic    out_ready = 1'b0;
  logic    sop_err;

  fft4_input_buffer #(.DATAWIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_ready (in_ready),
    .pair0_1  (pair0_1),
    .pair0_2  (pair0_2),
    .pair1_1  (pair1_1),
    .pair1_2  (pair1_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sop_err  (sop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int frames_out = 0;
  int sop_pulses = 0;
  int vprob = 100;
  bit sop_pend = 1'b0;
  item_t   send_q[$];
  frame_t  exp_q[$];
  sample_t part_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is the four samples since the last restart, x0 first
  task automatic model_accept(input item_t it);
    if (it.sop && part_q.size() != 0) begin
      part_q.delete();
      sop_pend = 1'b1;
    end
    part_q.push_back(it.data);
    if (part_q.size() == 4) begin
      exp_q.push_back({part_q[0], part_q[1], part_q[2], part_q[3]});
      part_q.delete();
    end
  endtask

  task automatic push(input bit sop, input sample_t d);
    send_q.push_back(item_t'{sop: sop, data: d});
  endtask

  task automatic drive();
    if (send_q.size() != 0 && int'($urandom_range(99)) < vprob) begin
      in_valid = 1'b1;
      in_data  = send_q[0].data;
      in_sop   = send_q[0].sop;
    end else begin
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_data  = $urandom;
    end
  endtask

  // Check outputs for this cycle, account for handshakes, advance one clock
  task automatic tick();
    item_t it;
    if (sop_err) sop_pulses++;
    chk("sop_err", sop_err, sop_pend);
    sop_pend = 1'b0;
    if (out_valid) begin
      chk("frame_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("frame_data", {pair0_1, pair1_1, pair0_2, pair1_2}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          frames_out++;
        end
      end
    end
    if (in_valid && in_ready) begin
      accepted++;
      it = send_q.pop_front();
      model_accept(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      drive();
      tick();
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    vprob = 100;
    for (int i = 0; i < 200; i++) begin
      if (send_q.size() == 0 && exp_q.size() == 0 && !out_valid) break;
      drive();
      tick();
    end
    chk("drained", send_q.size() + exp_q.size() + int'(out_valid), 0);
  endtask

  // Hold reset for two clocks, check reset state, release and check in_ready
  task automatic reset_hold();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    rst_n    = 1'b0;
    send_q.delete();
    exp_q.delete();
    part_q.delete();
    sop_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sop_err", sop_err, 0);
    chk("rst_pairs", {pair0_1, pair0_2, pair1_1, pair1_2}, 0);
    rst_n = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int f0;
    #2;
    reset_hold();

    // Directed frame, one-cycle latency and operand pairing
    out_ready = 1'b1;
    push(1'b1, 32'h0001_0001);
    push(1'b0, 32'h0002_0002);
    push(1'b0, 32'h0003_0003);
    push(1'b0, 32'h0004_0004);
    step(4);
    drive();
    chk("lat_out_valid", out_valid, 1);
    chk("p0_1", pair0_1, 32'h0001_0001);
    chk("p0_2", pair0_2, 32'h0003_0003);
    chk("p1_1", pair1_1, 32'h0002_0002);
    chk("p1_2", pair1_2, 32'h0004_0004);
    tick();
    chk("one_cycle_valid", out_valid, 0);

    // Backpressure: frame held for 10 cycles while more input is offered
    f0 = frames_out;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(i % 4 == 0, $urandom);
    step(4);
    a0 = accepted;
    for (int i = 0; i < 10; i++) begin
      drive();
      chk("hold_out_valid", out_valid, 1);
`ifndef FFT4_BUF_PINGPONG_EN
      chk("hold_in_ready", in_ready, 0);
`endif
      tick();
    end
`ifdef FFT4_BUF_PINGPONG_EN
    chk("hold_accepts", accepted - a0, 4);
    chk("hold_in_ready_end", in_ready, 0);
`else
    chk("hold_accepts", accepted - a0, 0);
`endif
    drain();
    chk("hold_frames", frames_out - f0, 2);

    // Sustained streaming throughput, 8 frames
    f0 = frames_out;
    a0 = accepted;
    for (int i = 0; i < 32; i++) push(i % 4 == 0, $urandom);
    out_ready = 1'b1;
    vprob = 100;
    step(StreamCycles);
    chk("stream_accepts", accepted - a0, 32);
    drain();
    chk("stream_frames", frames_out - f0, 8);

    // Mid-frame restart: A,B dropped, frame is C,D,E,F
    f0 = frames_out;
    sop_pulses = 0;
    push(1'b1, 32'hA0A0_000A);
    push(1'b0, 32'hB0B0_000B);
    push(1'b1, 32'hC0C0_000C);
    push(1'b0, 32'hD0D0_000D);
    push(1'b0, 32'hE0E0_000E);
    push(1'b0, 32'hF0F0_000F);
    drain();
    chk("restart_pulses", sop_pulses, 1);
    chk("restart_frames", frames_out - f0, 1);

    // Reset after 3 samples, then a clean frame
    for (int i = 0; i < 3; i++) push(i == 0, $urandom);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    reset_hold();
    f0 = frames_out;
    for (int i = 0; i < 4; i++) push(i == 0, $urandom);
    drain();
    chk("after_rst_frames", frames_out - f0, 1);

    // Reset with a FULL bank
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(i == 0, $urandom);
    step(5);
    chk("full_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_full_out_valid", out_valid, 0);
    reset_hold();
    out_ready = 1'b1;
    step(6);
    f0 = frames_out;
    for (int i = 0; i < 4; i++) push(i == 0, $urandom);
    drain();
    chk("after_full_rst_frames", frames_out - f0, 1);

    // Random traffic with occasional stray sop and random backpressure
    vprob = 70;
    for (int c = 0; c < 300; c++) begin
      if (send_q.size() < 4) begin
        for (int i = 0; i < 4; i++) push(i == 0 || $urandom_range(9) == 0, $urandom);
      end
      out_ready = ($urandom_range(99) < 60);
      drive();
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
